booth_mult_seq: RTL and testbench

- Iterative signed 32x32 Booth multiplier.
- Computes the next value of the 65-bit product/accumulator word {upper, lower, Booth extra bit} every cycle and holds it in its own 65-bit register.
- Sits in the multdiv unit between operand latch and the writeback mux.
- start/ready handshake; returns the low word plus a signed-overflow flag.

---
 rtl/booth_mult_seq.sv | 129 ++++++++++++
 tb/tb_booth_mult_seq.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/booth_mult_seq.sv
// Iterative signed WIDTH x WIDTH Booth multiplier with start/ready handshake.
// Define BOOTH_MULT_RADIX4_EN to build the modified Booth radix-4 variant (WIDTH/2 steps).
module booth_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             ready,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

`ifdef BOOTH_MULT_RADIX4_EN
  localparam int STEPS = WIDTH / 2;
  localparam int SW    = WIDTH + 2;
`else
  localparam int STEPS = WIDTH;
  localparam int SW    = WIDTH + 1;
`endif
  localparam int CW = $clog2(WIDTH);

  logic [1:0]       state_r;
  logic [WIDTH-1:0] mcand_r;
  logic [2*WIDTH:0] prod_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] result_r;
  logic             overflow_r;
  logic             ready_r;
  logic             busy_r;

  logic [SW-1:0]    upper_s;
  logic [SW-1:0]    m_ext_s;
  logic [SW-1:0]    addend_s;
  logic [SW-1:0]    sum_s;
  logic [2*WIDTH:0] prod_nxt_s;
  logic             last_s;
  logic             ovf_nxt_s;

  // One Booth step: pick the addend from the low product bits, add in extended width, shift.
  always_comb begin
    upper_s = {{(SW-WIDTH){prod_r[2*WIDTH]}}, prod_r[2*WIDTH:WIDTH+1]};
    m_ext_s = {{(SW-WIDTH){mcand_r[WIDTH-1]}}, mcand_r};
`ifdef BOOTH_MULT_RADIX4_EN
    case (prod_r[2:0])
      3'b001, 3'b010: addend_s = m_ext_s;
      3'b011:         addend_s = {m_ext_s[SW-2:0], 1'b0};
      3'b100:         addend_s = {SW{1'b0}} - {m_ext_s[SW-2:0], 1'b0};
      3'b101, 3'b110: addend_s = {SW{1'b0}} - m_ext_s;
      default:        addend_s = {SW{1'b0}};
    endcase
    sum_s      = upper_s + addend_s;
    prod_nxt_s = {sum_s, prod_r[WIDTH:2]};
`else
    case (prod_r[1:0])
      2'b01:   addend_s = m_ext_s;
      2'b10:   addend_s = {SW{1'b0}} - m_ext_s;
      default: addend_s = {SW{1'b0}};
    endcase
    sum_s      = upper_s + addend_s;
    prod_nxt_s = {sum_s, prod_r[WIDTH:1]};
`endif
    last_s    = (count_r == CW'(STEPS - 1));
    ovf_nxt_s = (prod_nxt_s[2*WIDTH:WIDTH+1] != {WIDTH{prod_nxt_s[WIDTH]}});
  end

  // Control FSM, operand/product registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= IDLE;
      mcand_r    <= {WIDTH{1'b0}};
      prod_r     <= {(2*WIDTH+1){1'b0}};
      count_r    <= {CW{1'b0}};
      result_r   <= {WIDTH{1'b0}};
      overflow_r <= 1'b0;
      ready_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          ready_r <= 1'b0;
          if (start) begin
            state_r <= RUN;
            mcand_r <= multiplicand;
            prod_r  <= {{WIDTH{1'b0}}, multiplier, 1'b0};
            count_r <= {CW{1'b0}};
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        RUN: begin
          prod_r  <= prod_nxt_s;
          count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
          if (last_s) begin
            state_r    <= DONE;
            result_r   <= prod_nxt_s[WIDTH:1];
            overflow_r <= ovf_nxt_s;
            ready_r    <= 1'b1;
            busy_r     <= 1'b0;
          end else begin
            state_r <= RUN;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          ready_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign result   = result_r;
  assign overflow = overflow_r;
  assign ready    = ready_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq: directed operand pairs with hand-computed products.
module tb_booth_mult_seq;
`ifdef BOOTH_MULT_RADIX4_EN
  localparam int LAT = 16;
`else
  localparam int LAT = 32;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [31:0] result;
  logic        overflow;
  logic        ready;
  logic        busy;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;
  logic [32:0] exp_q[$];
  int          acc_q[$];

  booth_mult_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .result(result), .overflow(overflow), .ready(ready), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else pass_cnt++;
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        int          a;
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        check("result", result, e[32:1]);
        check("overflow", {31'd0, overflow}, {31'd0, e[0]});
        check("latency", cyc - a, LAT);
      end
    end
  end

  // Called just after a negedge; returns at the negedge following the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit push,
                       input logic [31:0] r, input logic o);
    start = 1'b1;
    multiplicand = a;
    multiplier = b;
    if (push) begin
      exp_q.push_back({r, o});
      acc_q.push_back(cyc + 1);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ready(output int busy_cycles);
    bit found = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < LAT + 20; i++) begin
      if (ready === 1'b1) begin
        found = 1'b1;
        break;
      end
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
    end
    check("ready_seen", {31'd0, found}, 32'd1);
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r, input logic o);
    int bc;
    issue(a, b, 1'b1, r, o);
    wait_ready(bc);
    @(negedge clk);
  endtask

  initial begin
    int bc;
    reset = 1'b0;
    start = 1'b0;
    multiplicand = 32'd0;
    multiplier = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_result", result, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    issue(32'd3, 32'd7, 1'b1, 32'd21, 1'b0);
    wait_ready(bc);
    check("busy_cycles", bc, LAT);
    @(negedge clk);
    check("ready_one_cycle", {31'd0, ready}, 32'd0);

    op(32'hFFFF_FFFB, 32'd6,        32'hFFFF_FFE2, 1'b0);
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,        1'b0);
    op(32'h8000_0000, 32'h8000_0000, 32'd0,        1'b1);
    op(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    op(32'h0001_0000, 32'h0001_0000, 32'd0,        1'b1);
    op(32'h0000_7FFF, 32'h0001_0000, 32'h7FFF_0000, 1'b0);

    // Abort 9 x 9 mid-iteration; result must clear and no ready may appear.
    issue(32'd9, 32'd9, 1'b0, 32'd0, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ready", {31'd0, ready}, 32'd0);
    check("abort_result", result, 32'd0);
    repeat (2) @(negedge clk);
    op(32'd2, 32'd2, 32'd4, 1'b0);

    // Start while busy is ignored; start during the ready cycle is accepted.
    issue(32'd4, 32'd5, 1'b1, 32'd20, 1'b0);
    repeat (4) @(negedge clk);
    start = 1'b1;
    multiplicand = 32'd7;
    multiplier = 32'd7;
    @(negedge clk);
    start = 1'b0;
    wait_ready(bc);
    issue(32'd6, 32'd6, 1'b1, 32'd36, 1'b0);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_ready(bc);
    repeat (3) @(negedge clk);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
